// File: rtl/burst_ram_pkg.sv
// burst_ram shared types: FSM state encoding and default-build geometry.
// Build option: define BURST_RAM_WRAP_EN for critical-word-first bursts.
package burst_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WBURST,
    FIN
  } state_e;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 18;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_LATENCY    = 2;

  localparam int WORD_BYTES = DEF_DATA_W / 8;
  localparam int OFS_W      = $clog2(WORD_BYTES);
  localparam int BEAT_W     = $clog2(DEF_LINE_WORDS);
  localparam int DEPTH      = 2 ** (DEF_ADDR_W - OFS_W);

endpackage

// File: rtl/burst_ram_array.sv
// Single-port word array: synchronous write, registered read.
// Contents are never reset; only the read register is.
module burst_ram_array #(
  parameter int DATA_W = 32,
  parameter int AW     = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/burst_ram.sv
// Line-burst main memory with request/ready handshake and latency.
// Build option: BURST_RAM_WRAP_EN selects critical-word-first order.
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic              RVALID,
  output logic              BUSY,
  output logic              DONE
);

  localparam int WB  = DATA_W / 8;
  localparam int OW  = $clog2(WB);
  localparam int BW  = $clog2(LINE_WORDS);
  localparam int AW  = ADDR_W - OW;
  localparam int LNW = AW - BW;
  localparam int CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CW-1:0] WAIT_LAST =
    CW'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [BW:0] BEATS = (BW+1)'(LINE_WORDS);
  localparam logic [BW:0] LAST  = (BW+1)'(LINE_WORDS - 1);

  state_e          state_q, state_d;
  logic            we_q;
  logic [LNW-1:0]  line_q;
  logic [BW:0]     beat_q, beat_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic            rvalid_q, wready_q;
  logic [BW-1:0]   ofs;
  logic            rd_en, w_acc, accept;
  logic [AW-1:0]   waddr;
  logic            unused_addr;

  assign waddr  = ADDR[ADDR_W-1:OW];
  assign accept = (state_q == IDLE) && REQ;

`ifdef BURST_RAM_WRAP_EN
  logic [BW-1:0] start_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) start_q <= '0;
    else if (accept) start_q <= waddr[BW-1:0];
  end

  assign ofs = start_q + beat_q[BW-1:0];
  assign unused_addr = ^ADDR[OW-1:0];
`else
  assign ofs = beat_q[BW-1:0];
  assign unused_addr = ^{ADDR[OW-1:0], waddr[BW-1:0]};
`endif

  assign w_acc = (state_q == WBURST) && wready_q && WVALID;
  assign rd_en = (state_q == RBURST) && (beat_q != BEATS);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: if (REQ) begin
        beat_d = '0;
        wcnt_d = '0;
        if (LATENCY == 0) state_d = WE ? WBURST : RBURST;
        else state_d = WAIT;
      end
      WAIT: begin
        if (wcnt_q == WAIT_LAST) state_d = we_q ? WBURST : RBURST;
        else wcnt_d = wcnt_q + 1'b1;
      end
      // one extra cycle so the final registered beat is shown
      RBURST: begin
        if (beat_q == BEATS) state_d = FIN;
        else beat_d = beat_q + 1'b1;
      end
      WBURST: if (w_acc) begin
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      wcnt_q   <= '0;
      we_q     <= 1'b0;
      line_q   <= '0;
      rvalid_q <= 1'b0;
      wready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      wcnt_q   <= wcnt_d;
      rvalid_q <= rd_en;
      wready_q <= (state_q == WBURST) && !(w_acc && beat_q == LAST);
      if (accept) begin
        we_q   <= WE;
        line_q <= waddr[AW-1:BW];
      end
    end
  end

  burst_ram_array #(
    .DATA_W(DATA_W),
    .AW    (AW)
  ) u_array (
    .CLK  (CLK),
    .RST_N(RST_N),
    .we   (w_acc),
    .re   (rd_en),
    .addr ({line_q, ofs}),
    .wdata(WDATA),
    .rdata(RDATA)
  );

  assign RVALID = rvalid_q;
  assign WREADY = wready_q;
  assign BUSY   = (state_q != IDLE);
  assign DONE   = (state_q == FIN);

endmodule

// File: tb/tb_burst_ram.sv
// Directed bench for burst_ram: LATENCY=2 and LATENCY=0 instances.
// Expected data order follows BURST_RAM_WRAP_EN when defined.
module tb_burst_ram;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ = 1'b0;
  logic        WE = 1'b0;
  logic        WVALID = 1'b0;
  logic        sel = 1'b0;
  logic [17:0] ADDR = '0;
  logic [31:0] WDATA = '0;

  logic [31:0] rdata0, rdata1;
  logic        rvalid0, rvalid1, wready0, wready1;
  logic        busy0, busy1, done0, done1;

  wire req0 = REQ & ~sel;
  wire req1 = REQ & sel;
  wire wv0  = WVALID & ~sel;
  wire wv1  = WVALID & sel;

  wire [31:0] rdata  = sel ? rdata1 : rdata0;
  wire        rvalid = sel ? rvalid1 : rvalid0;
  wire        wready = sel ? wready1 : wready0;
  wire        busy   = sel ? busy1 : busy0;
  wire        done   = sel ? done1 : done0;

  burst_ram dut0 (
    .CLK(CLK), .RST_N(RST_N), .REQ(req0), .WE(WE), .ADDR(ADDR),
    .WDATA(WDATA), .WVALID(wv0), .WREADY(wready0), .RDATA(rdata0),
    .RVALID(rvalid0), .BUSY(busy0), .DONE(done0)
  );

  burst_ram #(.LATENCY(0)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .REQ(req1), .WE(WE), .ADDR(ADDR),
    .WDATA(WDATA), .WVALID(wv1), .WREADY(wready1), .RDATA(rdata1),
    .RVALID(rvalid1), .BUSY(busy1), .DONE(done1)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

`ifdef BURST_RAM_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    logic             s;
    logic             we;
    logic [17:0]      a;
    logic [3:0][31:0] d;
    int               gap;
    int               first;
    int               done;
  } vec_t;

  function automatic vec_t mk(logic s, logic we, logic [17:0] a,
                              logic [31:0] d0, logic [31:0] d1,
                              logic [31:0] d2, logic [31:0] d3,
                              int gap, int first, int dn);
    vec_t v;
    v.s = s; v.we = we; v.a = a;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.gap = gap; v.first = first; v.done = dn;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // Issue one request and watch a fixed window; collide re-raises REQ mid-burst.
  task automatic run(input vec_t v, input bit collide, input string tag);
    int e0, rel;
    int nv = 0;
    int i = 0;
    int first = -1;
    int donec = -1;
    int ndone = 0;
    bit gap_done = 0;
    logic [3:0][31:0] got;
    got = 'x;
    @(negedge CLK);
    sel = v.s; WE = v.we; ADDR = v.a; REQ = 1'b1;
    @(posedge CLK);
    #1;
    e0 = cyc;
    REQ = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge CLK);
      rel = cyc - e0;
      if (rvalid) begin
        if (nv < 4) got[nv] = rdata;
        nv++;
        if (first < 0) first = rel;
      end
      if (done) begin
        ndone++;
        if (donec < 0) donec = rel;
      end
      WVALID = 1'b0;
      if (wready) begin
        if (first < 0) first = rel;
        if (i < 4) begin
          if (i == v.gap && !gap_done) gap_done = 1;
          else begin
            WVALID = 1'b1;
            WDATA = v.d[i];
            i++;
          end
        end
      end
      if (collide && rel >= 3 && rel < 5) begin
        REQ = 1'b1; WE = 1'b1; WVALID = 1'b1; WDATA = 32'hdead_beef;
      end
      if (collide && rel == 5) begin
        REQ = 1'b0; WE = 1'b0;
      end
    end
    WVALID = 1'b0; REQ = 1'b0; WE = 1'b0;
    chk({tag, " first"}, 32'(first), 32'(v.first));
    chk({tag, " done_at"}, 32'(donec), 32'(v.done));
    chk({tag, " done_cnt"}, 32'(ndone), 32'd1);
    if (!v.we) begin
      chk({tag, " nbeats"}, 32'(nv), 32'd4);
      for (int b = 0; b < 4; b++)
        chk($sformatf("%s beat%0d", tag, b), got[b], v.d[b]);
    end
  endtask

  vec_t tbl[8];
  vec_t rd40;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit hit;
    rd40 = mk(0, 0, 18'h40, 32'h11, 32'h22, 32'h33, 32'h44, -1, 3, 7);
    tbl[0] = mk(0, 1, 18'h40, 32'h11, 32'h22, 32'h33, 32'h44, 2, 3, 8);
    tbl[1] = rd40;
    tbl[2] = WRAP ?
      mk(0, 0, 18'h48, 32'h33, 32'h44, 32'h11, 32'h22, -1, 3, 7) :
      mk(0, 0, 18'h48, 32'h11, 32'h22, 32'h33, 32'h44, -1, 3, 7);
    tbl[3] = mk(0, 1, 18'h8C, 32'hb0, 32'hb1, 32'hb2, 32'hb3, -1, 3, 7);
    tbl[4] = WRAP ?
      mk(0, 0, 18'h80, 32'hb1, 32'hb2, 32'hb3, 32'hb0, -1, 3, 7) :
      mk(0, 0, 18'h80, 32'hb0, 32'hb1, 32'hb2, 32'hb3, -1, 3, 7);
    tbl[5] = mk(1, 1, 18'h3FFF0, 32'hc0, 32'hc1, 32'hc2, 32'hc3, -1, 1, 5);
    tbl[6] = mk(1, 0, 18'h3FFF0, 32'hc0, 32'hc1, 32'hc2, 32'hc3, -1, 1, 5);
    tbl[7] = WRAP ?
      mk(1, 0, 18'h3FFFC, 32'hc3, 32'hc0, 32'hc1, 32'hc2, -1, 1, 5) :
      mk(1, 0, 18'h3FFFC, 32'hc0, 32'hc1, 32'hc2, 32'hc3, -1, 1, 5);

    #12;
    chk("reset rvalid0", 32'(rvalid0), 32'd0);
    chk("reset rdata0", rdata0, 32'd0);
    chk("reset busy0", 32'(busy0), 32'd0);
    chk("reset done0", 32'(done0), 32'd0);
    chk("reset wready0", 32'(wready0), 32'd0);
    chk("reset busy1", 32'(busy1), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int t = 0; t < 8; t++) run(tbl[t], 1'b0, $sformatf("vec%0d", t));

    run(rd40, 1'b1, "collide");
    run(rd40, 1'b0, "after_collide");

    @(negedge CLK);
    sel = 1'b0; WE = 1'b0; ADDR = 18'h40; REQ = 1'b1;
    @(posedge CLK);
    #1;
    REQ = 1'b0;
    n = 0;
    hit = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (rvalid0) n++;
      if (n == 2) begin
        hit = 1;
        break;
      end
    end
    chk("rst second_beat_seen", 32'(hit), 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    chk("rst rvalid", 32'(rvalid0), 32'd0);
    chk("rst busy", 32'(busy0), 32'd0);
    chk("rst done", 32'(done0), 32'd0);
    chk("rst rdata", rdata0, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    run(rd40, 1'b0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
